// File: rtl/mcp3008_scanner.sv
// Scans a masked set of MCP3008 channels in ascending order over SPI mode 0,0.
// Keeps the latest 10-bit result per channel and strobes each conversion.
module mcp3008_scanner #(
    parameter int NUM_CH  = 8,
    parameter int CLK_DIV = 16,
    parameter int GAP     = 8,
    parameter int SGL     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 start,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic                 miso,
    output logic                 cs_n,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 busy,
    output logic                 sample_valid,
    output logic [2:0]           sample_ch,
    output logic [9:0]           sample_data,
    output logic                 frame_done,
    output logic [NUM_CH*10-1:0] ch_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam int CMAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4:0]           bit_q, bit_d;
    logic                 phase_q, phase_d;
    logic [NUM_CH-1:0]    pend_q, pend_d;
    logic [2:0]           ch_q, ch_d;
    logic [9:0]           shreg_q, shreg_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 busy_q, busy_d;
    logic                 sample_valid_q, sample_valid_d;
    logic [2:0]           sample_ch_q, sample_ch_d;
    logic [9:0]           sample_data_q, sample_data_d;
    logic                 frame_done_q, frame_done_d;
    logic [NUM_CH*10-1:0] ch_data_q, ch_data_d;

    function automatic logic [2:0] first_ch(input logic [NUM_CH-1:0] m);
        first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) first_ch = 3'(i);
        end
    endfunction

    function automatic logic [NUM_CH-1:0] drop_ch(input logic [NUM_CH-1:0] m, input logic [2:0] c);
        drop_ch = m;
        for (int i = 0; i < NUM_CH; i++) begin
            if (3'(i) == c) drop_ch[i] = 1'b0;
        end
    endfunction

    // Command word: start bit, SGL/DIFF, channel MSB first, then zeros.
    function automatic logic cmd_bit(input logic [4:0] b, input logic [2:0] c);
        case (b)
            5'd0:    cmd_bit = 1'b1;
            5'd1:    cmd_bit = (SGL != 0);
            5'd2:    cmd_bit = c[2];
            5'd3:    cmd_bit = c[1];
            5'd4:    cmd_bit = c[0];
            default: cmd_bit = 1'b0;
        endcase
    endfunction

    logic [9:0]        data_nxt;
    logic [NUM_CH-1:0] launch_mask;
    logic              launch;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_d          = bit_q;
        phase_d        = phase_q;
        pend_d         = pend_q;
        ch_d           = ch_q;
        shreg_d        = shreg_q;
        cs_n_d         = cs_n_q;
        sclk_d         = sclk_q;
        mosi_d         = mosi_q;
        busy_d         = busy_q;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        sample_data_d  = sample_data_q;
        frame_done_d   = 1'b0;
        ch_data_d      = ch_data_q;
        data_nxt       = {shreg_q[8:0], miso};
        launch_mask    = '0;
        launch         = 1'b0;

        case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if ((enable || start) && (|ch_mask)) begin
                    launch      = 1'b1;
                    launch_mask = ch_mask;
                end
            end
            S_SETUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_SHIFT;
                    bit_d   = 5'd0;
                    phase_d = 1'b0;
                    cnt_d   = DIV_LOAD;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                    cnt_d   = DIV_LOAD;
                end else begin
                    // Last cycle of the high phase: the ADC bit is stable here.
                    if (bit_q >= 5'd7) shreg_d = data_nxt;
                    if (bit_q == 5'd16) begin
                        state_d        = S_GAP;
                        sclk_d         = 1'b0;
                        cs_n_d         = 1'b1;
                        mosi_d         = 1'b0;
                        cnt_d          = GAP_LOAD;
                        sample_valid_d = 1'b1;
                        sample_ch_d    = ch_q;
                        sample_data_d  = data_nxt;
                        frame_done_d   = (pend_q == '0);
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (3'(k) == ch_q) ch_data_d[k*10 +: 10] = data_nxt;
                        end
                    end else begin
                        bit_d   = 5'(bit_q + 5'd1);
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                        mosi_d  = cmd_bit(5'(bit_q + 5'd1), ch_q);
                        cnt_d   = DIV_LOAD;
                    end
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (|pend_q) begin
                    launch      = 1'b1;
                    launch_mask = pend_q;
                end else if (enable && (|ch_mask)) begin
                    launch      = 1'b1;
                    launch_mask = ch_mask;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase

        // Start the lowest pending channel; skipped channels cost no bus time.
        if (launch) begin
            state_d = S_SETUP;
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            mosi_d  = 1'b1;
            cnt_d   = DIV_LOAD;
            busy_d  = 1'b1;
            ch_d    = first_ch(launch_mask);
            pend_d  = drop_ch(launch_mask, first_ch(launch_mask));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            bit_q          <= '0;
            phase_q        <= 1'b0;
            pend_q         <= '0;
            ch_q           <= '0;
            shreg_q        <= '0;
            cs_n_q         <= 1'b1;
            sclk_q         <= 1'b0;
            mosi_q         <= 1'b0;
            busy_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= '0;
            sample_data_q  <= '0;
            frame_done_q   <= 1'b0;
            ch_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_q          <= bit_d;
            phase_q        <= phase_d;
            pend_q         <= pend_d;
            ch_q           <= ch_d;
            shreg_q        <= shreg_d;
            cs_n_q         <= cs_n_d;
            sclk_q         <= sclk_d;
            mosi_q         <= mosi_d;
            busy_q         <= busy_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            sample_data_q  <= sample_data_d;
            frame_done_q   <= frame_done_d;
            ch_data_q      <= ch_data_d;
        end
    end

    assign cs_n         = cs_n_q;
    assign sclk         = sclk_q;
    assign mosi         = mosi_q;
    assign busy         = busy_q;
    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign sample_data  = sample_data_q;
    assign frame_done   = frame_done_q;
    assign ch_data      = ch_data_q;

endmodule

// File: tb/tb_mcp3008_scanner.sv
// Bench for mcp3008_scanner: behavioural MCP3008 model plus expected-sequence
// reference derived from the channel mask and per-channel response table.
module tb_mcp3008_scanner;

    localparam int CLK_DIV    = 16;
    localparam int GAP        = 8;
    localparam int PERIOD_CYC = 35 * CLK_DIV + GAP;

    logic        clk = 1'b0;
    logic        rst_n, enable, start, miso;
    logic [7:0]  ch_mask;
    logic        cs_n, sclk, mosi, busy, sample_valid, frame_done;
    logic [2:0]  sample_ch;
    logic [9:0]  sample_data;
    logic [79:0] ch_data;

    logic        start2, miso2;
    logic [3:0]  mask2;
    logic        cs2, sclk2, mosi2, busy2, valid2, done2;
    logic [2:0]  ch2;
    logic [9:0]  data2;
    logic [39:0] chdata2;

    always #5 clk = ~clk;

    mcp3008_scanner #(.NUM_CH(8), .CLK_DIV(CLK_DIV), .GAP(GAP), .SGL(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .ch_mask(ch_mask),
        .miso(miso), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .busy(busy),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
        .frame_done(frame_done), .ch_data(ch_data)
    );

    mcp3008_scanner #(.NUM_CH(4), .CLK_DIV(2), .GAP(1), .SGL(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(1'b0), .start(start2), .ch_mask(mask2),
        .miso(miso2), .cs_n(cs2), .sclk(sclk2), .mosi(mosi2), .busy(busy2),
        .sample_valid(valid2), .sample_ch(ch2), .sample_data(data2),
        .frame_done(done2), .ch_data(chdata2)
    );

    int checks = 0;
    int errors = 0;
    logic [9:0] resp    [8];
    logic [9:0] chModel [8];

    // ADC model: decodes the command from DIN, drives DOUT one bit per SCLK period.
    int          riseCnt = 0;
    logic [16:0] rxWord  = '0;
    logic [2:0]  rxCh    = '0;
    logic [16:0] rxWord2 = '0;

    always @(negedge cs_n) begin
        riseCnt = 0;
        rxWord  = '0;
    end

    always @(posedge sclk) begin
        logic [9:0] w;
        if (!cs_n) begin
            rxWord = {rxWord[15:0], mosi};
            if (riseCnt == 4) rxCh = rxWord[2:0];
            w = resp[rxCh];
            if (riseCnt == 5)                       miso = 1'b1;
            else if (riseCnt >= 7 && riseCnt <= 16) miso = w[16 - riseCnt];
            else                                    miso = 1'b0;
            riseCnt++;
        end
    end

    always @(negedge cs2) rxWord2 = '0;
    always @(posedge sclk2) if (!cs2) rxWord2 = {rxWord2[15:0], mosi2};

    int   cyc = 0, fallCount = 0, lastFall = 0, fallSpacing = 0;
    logic prevCs = 1'b1;
    always @(posedge clk) begin
        cyc++;
        if (prevCs && !cs_n) begin
            fallCount++;
            fallSpacing = cyc - lastFall;
            lastFall    = cyc;
        end
        prevCs = cs_n;
    end

    function automatic logic [79:0] modelWord();
        for (int i = 0; i < 8; i++) modelWord[i*10 +: 10] = chModel[i];
    endfunction

    task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitSample();
        int n = 0;
        @(negedge clk);
        while (!sample_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("sample_timeout", sample_valid, 1);
    endtask

    // act: 1 = load newMask, 2 = drop enable, applied after channel actCh reports.
    task automatic applyStimulus(input logic [7:0] m, input bit contFromPrev,
                                 input int actCh, input int act, input logic [7:0] newMask);
        int hi = 0;
        bit first = 1'b1;
        for (int i = 0; i < 8; i++) if (m[i]) hi = i;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                waitSample();
                checkOutput("sample_ch", sample_ch, i);
                checkOutput("sample_data", sample_data, resp[i]);
                checkOutput("frame_done", frame_done, (i == hi));
                chModel[i] = resp[i];
                checkOutput("ch_data", ch_data, modelWord());
                checkOutput("mosi_word", rxWord, {1'b1, 1'b1, 3'(i), 12'b0});
                checkOutput("rise_count", riseCnt, 17);
                if (!first || contFromPrev) checkOutput("cs_spacing", fallSpacing, PERIOD_CYC);
                first = 1'b0;
                if (i == actCh && act == 1) ch_mask = newMask;
                if (i == actCh && act == 2) enable = 1'b0;
            end
        end
    endtask

    initial begin
        int         base, n;
        logic [7:0] m;

        rst_n = 1'b0; enable = 1'b0; start = 1'b0; ch_mask = '0; miso = 1'b0;
        start2 = 1'b0; mask2 = '0; miso2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            resp[i]    = '0;
            chModel[i] = '0;
        end

        repeat (3) @(negedge clk);
        checkOutput("rst_cs_n", cs_n, 1);
        checkOutput("rst_sclk", sclk, 0);
        checkOutput("rst_mosi", mosi, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", sample_valid, 0);
        checkOutput("rst_done", frame_done, 0);
        checkOutput("rst_ch_data", ch_data, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("idle_cs_n", cs_n, 1);

        // One-shot on channel 3, with a second start while busy.
        resp[3] = 10'h2A5;
        ch_mask = 8'h08;
        base    = fallCount;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("cs_fall_latency", cs_n, 0);
        checkOutput("busy_start", busy, 1);
        repeat (200) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        applyStimulus(8'h08, 1'b0, -1, 0, 8'h00);
        checkOutput("ch3_slot", ch_data[39:30], 10'h2A5);
        repeat (GAP - 1) @(negedge clk);
        checkOutput("busy_in_gap", busy, 1);
        @(negedge clk);
        checkOutput("busy_after_gap", busy, 0);
        repeat (800) @(negedge clk);
        checkOutput("oneshot_falls", fallCount - base, 1);

        // Random one-shot frames; mask is scrambled right after the frame latches it.
        for (int f = 0; f < 3; f++) begin
            m = 8'($urandom_range(1, 255));
            for (int i = 0; i < 8; i++) resp[i] = 10'($urandom_range(0, 1023));
            ch_mask = m;
            start   = 1'b1;
            @(negedge clk);
            start   = 1'b0;
            ch_mask = 8'($urandom);
            applyStimulus(m, 1'b0, -1, 0, 8'h00);
            repeat (GAP + 2) @(negedge clk);
            checkOutput("rand_idle", busy, 0);
        end

        // Continuous scan, mask change mid-frame, then enable dropped mid-frame.
        for (int i = 0; i < 8; i++) resp[i] = 10'(100 * i + 5);
        ch_mask = 8'hFF;
        enable  = 1'b1;
        applyStimulus(8'hFF, 1'b0, -1, 0, 8'h00);
        applyStimulus(8'hFF, 1'b1, 1, 1, 8'hA1);
        applyStimulus(8'hA1, 1'b1, 0, 2, 8'h00);
        repeat (GAP + 2) @(negedge clk);
        checkOutput("cont_end_busy", busy, 0);
        base = fallCount;
        repeat (1500) @(negedge clk);
        checkOutput("cont_end_quiet", fallCount - base, 0);

        // Enable with an empty mask stays idle.
        ch_mask = 8'h00;
        enable  = 1'b1;
        base    = fallCount;
        repeat (1000) @(negedge clk);
        checkOutput("zero_mask_falls", fallCount - base, 0);
        checkOutput("zero_mask_busy", busy, 0);
        checkOutput("zero_mask_cs_n", cs_n, 1);
        enable = 1'b0;

        // Asynchronous reset in the middle of a shift on channel 2.
        resp[2] = 10'h155;
        ch_mask = 8'h04;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (riseCnt < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_b9", (riseCnt >= 10), 1);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) chModel[i] = '0;
        checkOutput("arst_cs_n", cs_n, 1);
        checkOutput("arst_sclk", sclk, 0);
        checkOutput("arst_mosi", mosi, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_valid", sample_valid, 0);
        checkOutput("arst_ch", sample_ch, 0);
        checkOutput("arst_data", sample_data, 0);
        checkOutput("arst_ch_data", ch_data, modelWord());
        @(negedge clk);
        rst_n = 1'b1;
        base  = fallCount;
        repeat (1000) @(negedge clk);
        checkOutput("post_rst_quiet", fallCount - base, 0);
        checkOutput("post_rst_cs_n", cs_n, 1);

        // Pseudo-differential build: command bit 1 must be 0.
        mask2  = 4'b0100;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!valid2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("diff_timeout", valid2, 1);
        checkOutput("diff_mosi_word", rxWord2, {1'b1, 1'b0, 3'd2, 12'b0});
        checkOutput("diff_ch", ch2, 2);
        checkOutput("diff_data", data2, 10'h3FF);
        checkOutput("diff_slot", chdata2[29:20], 10'h3FF);
        checkOutput("diff_done", done2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcp3008_scanner.md
# mcp3008_scanner

Multi-channel scanner for the MCP3008 10-bit SPI ADC. It generates CS/SCLK/MOSI, reads a masked set of channels in ascending order, and holds the latest result for every channel in a register bank. Each conversion is also reported on a 1-cycle valid strobe. It sits between the board ADC pins and the motor-control logic (accel pedal, phase-current and bus-voltage sensing), replacing single-channel, counter-slot ADC polling.

## Interface
Parameters:
- NUM_CH, 8: channels scanned, 1..8; channel indices 0..NUM_CH-1.
- CLK_DIV, 16: clk cycles per SCLK half-period, ≥2.
- GAP, 8: clk cycles cs_n is held high between conversions, ≥1.
- SGL, 1: 1 = single-ended, 0 = pseudo-differential; sent as the SGL/DIFF bit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  continuous scanning while high
- start  in  1  1-cycle pulse: run one frame; ignored while busy
- ch_mask  in  NUM_CH  channel enable bits; sampled at frame start
- miso  in  1  ADC DOUT
- cs_n  out  1  ADC CS/SHDN
- sclk  out  1  ADC CLK; idle low (SPI mode 0,0)
- mosi  out  1  ADC DIN
- busy  out  1  high from frame start until return to IDLE
- sample_valid  out  1  1-cycle strobe, one per conversion
- sample_ch  out  3  channel of the current strobe
- sample_data  out  10  result of the current strobe
- frame_done  out  1  1-cycle strobe with the last sample_valid of a frame
- ch_data  out  NUM_CH*10  latest result per channel; channel k at bits [10k+9:10k]

## Operation
- States: IDLE, SETUP, SHIFT, GAP.
- IDLE: cs_n=1, sclk=0, mosi=0.
  - Frame starts when (enable or start) and the latched mask (ch_mask & valid-channel bits) is nonzero.
  - The mask is latched at frame start; busy=1. An all-zero mask keeps the block in IDLE.
- Channel order: ascending index. Masked channels are skipped with no bus activity.
- SETUP: cs_n=0, sclk=0 for CLK_DIV cycles; mosi = bit 0.
- SHIFT: 17 bit periods, index b=0..16. Each period is CLK_DIV cycles sclk low, then CLK_DIV cycles sclk high.
  - mosi changes only at the start of the low phase.
  - Bits: b0=1 (start), b1=SGL, b2..b4 = channel[2:0] MSB first; mosi=0 for b5..b16.
  - miso is captured on the last clk cycle of each high phase.
  - b5 (sample) and b6 (null) are discarded; b7..b16 = B9..B0.
- After the b16 capture: sclk=0, cs_n=1, then GAP.
  - On the first GAP cycle: sample_valid=1, sample_ch and sample_data updated, and the matching ch_data slot is written.
  - frame_done=1 on the same cycle if no higher masked channel remains.
- After GAP cycles, the block goes to SETUP for the next masked channel. At frame end:
  - if enable=1, it re-latches ch_mask and starts a new frame directly from GAP, without passing through IDLE;
  - otherwise it goes to IDLE and busy=0.
- enable falling or ch_mask changing mid-frame: the current conversion completes and its result is reported.
  - Mask change: takes effect at the next frame.
  - enable low: the remaining channels of the current frame are still converted. A frame started by start always runs to completion.
- The bus is never aborted except by reset.
- Reset (asynchronous, any state): cs_n=1, sclk=0, mosi=0, busy=0, sample_valid=0, frame_done=0, sample_ch=0, sample_data=0, all ch_data=0, state=IDLE.
- Outputs are registered; no glitches on cs_n or sclk.

## Timing
- Conversion: CLK_DIV + 34·CLK_DIV clk cycles with cs_n=0, followed by GAP cycles with cs_n=1.
- cs_n fall to next cs_n fall: 35·CLK_DIV + GAP cycles.
- start/enable sampled at cycle t → cs_n falls at t+1.
- Last miso capture → sample_valid on the next clk cycle. ch_data is visible on the same cycle as sample_valid.
- Defaults at 27 MHz: SCLK ≈ 844 kHz; 568 cycles (≈21 µs) per conversion; 8-channel frame ≈ 168 µs.
- MISO is captured CLK_DIV−1 cycles after the sclk rising edge, giving ≥ CLK_DIV−1 cycles of setup against the ADC falling-edge output.

## Test plan
- Reset with rst_n=0 mid-SHIFT (ch 2, b=9).
  - cs_n=1, sclk=0 within the same cycle, with no clk edge needed.
  - All strobes and ch_data read 0; after release the block idles until start.
- One-shot, ch_mask=8'h08, start pulse, ADC model returns 10'h2A5 on ch3.
  - mosi bits 1,1,0,1,1 on the first five rising edges; exactly 17 sclk rising edges.
  - sample_ch=3, sample_data=10'h2A5, frame_done=1 on the same cycle.
  - ch_data[39:30]=10'h2A5; busy falls after GAP.
- Continuous, enable=1, mask=8'hFF, model returns 100·ch+5.
  - sample_ch sequence 0..7, repeating; frame_done only with ch7.
  - cs_n fall-to-fall spacing 568 cycles.
- Mask skipping: mask=8'b1010_0001.
  - Only channels 0, 5, 7 are converted.
  - mask=0 with enable=1: cs_n stays 1, busy=0.
- enable deasserted at b=10 of ch1 (frame with mask=8'h07).
  - Conversions for ch1 and ch2 complete; frame_done is reported with ch2.
  - Then IDLE, busy=0; no further cs_n activity.
- start asserted while busy: ignored, and the frame count is unchanged.
  - SGL=0 build: mosi b1=0.
